// File: rtl/cpu_types_pkg.sv
// Purpose: types shared by the CPU request path and the memory-side responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Responder sequencing: one data or instruction RAM access at a time,
    // followed by a single hit cycle before the next request is considered.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        HIT  = 2'd3
    } resp_state_t;

endpackage

// File: rtl/request_responder_if.sv
// Purpose: bundle of the CPU request/response signals between the request unit and the responder.
// Latency: n/a (wiring only).
// Backpressure: requests are held by the CPU side until the matching hit pulse.
//
// Modports:
//   cpu  - request unit: drives iREN/dREN/dWEN/addresses/store data, receives hits and load data.
//   resp - responder: the opposite direction of cpu.
interface request_responder_if;
    import cpu_types_pkg::*;

    logic  iREN;
    logic  dREN;
    logic  dWEN;
    word_t iaddr;
    word_t daddr;
    word_t dstore;
    logic  ihit;
    logic  dhit;
    word_t iload;
    word_t dload;

    modport cpu (
        output iREN, dREN, dWEN, iaddr, daddr, dstore,
        input  ihit, dhit, iload, dload
    );

    modport resp (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore,
        output ihit, dhit, iload, dload
    );

endinterface

// File: rtl/request_responder.sv
// Purpose: serializes instruction fetches and data reads/writes onto a single-ported RAM, data first.
// Latency: request seen in IDLE at cycle t -> RAM strobe t+1..t+1+LAT -> hit pulse at t+2+LAT.
// Backpressure: requests are held by the requester until their hit; only sampled in IDLE.
//
// Ports:
//   CLK, RST                  clock (rising edge), asynchronous active-high reset
//   iREN, iaddr               instruction fetch request and address
//   dREN, dWEN, daddr, dstore data read / write request, address and store data
//   ihit, iload               fetch complete pulse and fetched word (held until next ihit)
//   dhit, dload               data complete pulse and loaded word (held until next read dhit)
//   ramREN, ramWEN            RAM strobes, held LAT+1 cycles per access, never both
//   ramaddr, ramstore         RAM address and write data, latched at request acceptance
//   ramload                   RAM read data, valid in the final wait cycle
module request_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int CNT_W = 4
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iREN,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t iaddr,
    input  word_t daddr,
    input  word_t dstore,
    output logic  ihit,
    output logic  dhit,
    output word_t iload,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAT);

    resp_state_t      state;
    resp_state_t      state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    // Next values of the registered outputs. Every output is a flop so the
    // RAM and the CPU never see a combinational path from our inputs.
    logic  ihit_n;
    logic  dhit_n;
    word_t iload_n;
    word_t dload_n;
    logic  ramREN_n;
    logic  ramWEN_n;
    word_t ramaddr_n;
    word_t ramstore_n;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        ihit_n     = 1'b0;
        dhit_n     = 1'b0;
        iload_n    = iload;
        dload_n    = dload;
        ramREN_n   = ramREN;
        ramWEN_n   = ramWEN;
        ramaddr_n  = ramaddr;
        ramstore_n = ramstore;

        unique case (state)
            IDLE: begin
                if (dREN || dWEN) begin
                    // dWEN wins when both are raised: the access is a write.
                    state_n    = DACC;
                    cnt_n      = '0;
                    ramREN_n   = !dWEN;
                    ramWEN_n   = dWEN;
                    ramaddr_n  = daddr;
                    ramstore_n = dstore;
                end else if (iREN) begin
                    state_n   = IACC;
                    cnt_n     = '0;
                    ramREN_n  = 1'b1;
                    ramWEN_n  = 1'b0;
                    ramaddr_n = iaddr;
                end
            end

            DACC: begin
                if (cnt == LAST_CNT) begin
                    state_n  = HIT;
                    cnt_n    = '0;
                    ramREN_n = 1'b0;
                    ramWEN_n = 1'b0;
                    dhit_n   = 1'b1;
                    // The strobe register still tells us which kind of access
                    // this was; writes must leave dload alone.
                    if (!ramWEN) begin
                        dload_n = ramload;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            IACC: begin
                if (cnt == LAST_CNT) begin
                    state_n  = HIT;
                    cnt_n    = '0;
                    ramREN_n = 1'b0;
                    ihit_n   = 1'b1;
                    iload_n  = ramload;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            HIT: begin
                // The hit flop is already high this cycle; one dead cycle
                // lets the requester drop its request before we resample.
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            iload    <= '0;
            dload    <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            ihit     <= ihit_n;
            dhit     <= dhit_n;
            iload    <= iload_n;
            dload    <= dload_n;
            ramREN   <= ramREN_n;
            ramWEN   <= ramWEN_n;
            ramaddr  <= ramaddr_n;
            ramstore <= ramstore_n;
        end
    end

endmodule

// File: tb/tb_request_responder.sv
// Purpose: self-checking bench for request_responder with a RAM model and a hit scoreboard.
// Latency: expects hits at t+2+LAT, and a queued fetch LAT+3 cycles after a data hit.
// Backpressure: requests are held until their hit, or dropped early in the abort/drop sequences.
module tb_request_responder;

    localparam int LAT   = 2;
    localparam int CNT_W = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;

    request_responder #(.LAT(LAT), .CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .iaddr    (iaddr),
        .daddr    (daddr),
        .dstore   (dstore),
        .ihit     (ihit),
        .dhit     (dhit),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_d;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] data;
        int          hit_cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        i;
        logic        d;
        logic        w;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] ds;
    } vec_t;

    vec_t vecs[7];

    // ---------------- RAM model ----------------
    // Read data is only valid in the final wait cycle of a strobe run.
    logic [31:0] wr_mem [256];
    bit   [255:0] wr_vld;
    int           scnt = 0;

    function automatic logic [31:0] base_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C010004 : {a[15:0], 16'hC0DE};
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            scnt <= 0;
        end else begin
            if (ramREN || ramWEN) scnt <= scnt + 1;
            else                  scnt <= 0;
            if (ramWEN) begin
                wr_mem[ramaddr[9:2]] <= ramstore;
                wr_vld[ramaddr[9:2]] <= 1'b1;
            end
        end
    end

    always_comb begin
        ramload = 32'hBAD0BAD0;
        if (ramREN && scnt == LAT) begin
            ramload = wr_vld[ramaddr[9:2]] ? wr_mem[ramaddr[9:2]] : base_word(ramaddr);
        end
    end

    // ---------------- reference memory contents ----------------
    logic [31:0] model [logic [31:0]];
    logic [31:0] exp_dload = '0;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model.exists(a) ? model[a] : base_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int run = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                run = 0;
            end else begin
                if (ramREN || ramWEN) begin
                    run++;
                    if (sb.size() == 0) begin
                        check("strobe_unexpected", 32'(1), 32'(0));
                    end else begin
                        check("strobe_kind", {30'b0, ramREN, ramWEN},
                              sb[0].is_wr ? 32'h1 : 32'h2);
                        check("ramaddr", ramaddr, sb[0].addr);
                        if (sb[0].is_wr) check("ramstore", ramstore, sb[0].store);
                    end
                end else if (run > 0) begin
                    check("strobe_len", 32'(run), 32'(LAT + 1));
                    run = 0;
                end

                if (ihit || dhit) begin
                    check("hit_overlap", 32'(ihit && dhit), 32'(0));
                    if (sb.size() == 0) begin
                        check("hit_unexpected", {30'b0, ihit, dhit}, 32'(0));
                    end else begin
                        e = sb.pop_front();
                        check("hit_kind", {31'b0, dhit}, {31'b0, e.is_d});
                        check("hit_cycle", 32'(cyc), 32'(e.hit_cyc));
                        if (e.is_d) check("dload", dload, e.data);
                        else        check("iload", iload, e.data);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // drop_after > 0 drops the data request (and scrambles daddr) that many
    // cycles after it was raised; otherwise each request is held until its hit.
    task automatic do_req(input logic i, input logic d, input logic w,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] ds, input int drop_after);
        int   k;
        exp_t e;
        @(posedge CLK); #1;
        k = cyc;
        if (d || w) begin
            e.is_d    = 1'b1;
            e.is_wr   = w;
            e.addr    = da;
            e.store   = ds;
            if (w) begin
                model[da] = ds;
                e.data    = exp_dload;
            end else begin
                e.data    = model_rd(da);
                exp_dload = e.data;
            end
            e.hit_cyc = k + 2 + LAT;
            sb.push_back(e);
        end
        if (i) begin
            e.is_d    = 1'b0;
            e.is_wr   = 1'b0;
            e.addr    = ia;
            e.store   = '0;
            e.data    = model_rd(ia);
            e.hit_cyc = (d || w) ? k + 2 * LAT + 5 : k + 2 + LAT;
            sb.push_back(e);
        end
        iREN = i; dREN = d; dWEN = w;
        iaddr = ia; daddr = da; dstore = ds;
        for (int n = 1; n <= 60; n++) begin
            @(posedge CLK); #1;
            if (dhit) begin dREN = 1'b0; dWEN = 1'b0; end
            if (ihit) iREN = 1'b0;
            if (drop_after > 0 && n == drop_after) begin
                dREN = 1'b0; dWEN = 1'b0;
                daddr = 32'hFFF0; dstore = 32'h0;
            end
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check("timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{i:1'b1, d:1'b0, w:1'b0, ia:32'h40,  da:32'h0,   ds:32'h0};
        vecs[1] = '{i:1'b1, d:1'b1, w:1'b0, ia:32'h44,  da:32'h100, ds:32'h0};
        vecs[2] = '{i:1'b0, d:1'b0, w:1'b1, ia:32'h0,   da:32'h200, ds:32'hDEADBEEF};
        vecs[3] = '{i:1'b0, d:1'b1, w:1'b0, ia:32'h0,   da:32'h200, ds:32'h0};
        vecs[4] = '{i:1'b0, d:1'b1, w:1'b1, ia:32'h0,   da:32'h300, ds:32'h12345678};
        vecs[5] = '{i:1'b0, d:1'b1, w:1'b0, ia:32'h0,   da:32'h300, ds:32'h0};
        vecs[6] = '{i:1'b1, d:1'b0, w:1'b0, ia:32'h200, da:32'h0,   ds:32'h0};

        // Reset values while reset is held.
        #1;
        check("rst_strobes_hits", {28'b0, ihit, dhit, ramREN, ramWEN}, 32'(0));
        check("rst_iload", iload, 32'h0);
        check("rst_dload", dload, 32'h0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // Idle with no requests: nothing moves for 20 cycles.
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            check("idle_outs", {28'b0, ihit, dhit, ramREN, ramWEN}, 32'(0));
        end
        check("idle_ramaddr", ramaddr, 32'h0);

        for (int v = 0; v < 7; v++) begin
            do_req(vecs[v].i, vecs[v].d, vecs[v].w,
                   vecs[v].ia, vecs[v].da, vecs[v].ds, 0);
            repeat (2) @(posedge CLK);
        end

        // Reset in the second IACC cycle aborts the fetch.
        begin
            exp_t e;
            @(posedge CLK); #1;
            e.is_d = 1'b0; e.is_wr = 1'b0; e.addr = 32'h44;
            e.store = '0; e.data = '0; e.hit_cyc = 0;
            sb.push_back(e);
            iREN = 1'b1; iaddr = 32'h44;
            repeat (2) @(posedge CLK);
            #1;
            check("abort_pre_ren", {31'b0, ramREN}, 32'(1));
            RST = 1'b1; iREN = 1'b0;
            #1;
            check("abort_ren", {31'b0, ramREN}, 32'(0));
            check("abort_ramaddr", ramaddr, 32'h0);
            check("abort_iload", iload, 32'h0);
            sb.delete();
            repeat (2) @(posedge CLK);
            #1 RST = 1'b0;
            exp_dload = '0;
            repeat (10) @(posedge CLK);
        end
        do_req(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 0);
        repeat (2) @(posedge CLK);

        // Data read dropped after one DACC cycle still completes.
        do_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 32'h0, 2);
        repeat (2) @(posedge CLK);

        // Fetch after the dropped read: iload reflects the new fetch only.
        do_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0);

        repeat (5) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
